nnet_frame_adapter: RTL and testbench
=====================================

Name: nnet_frame_adapter

Overview:
Parametrised adapter between the RFNoC vector wrapper's 32-bit sample streams and an HLS neural-net core. It converts sample width both ways, with saturation or truncation on the way in and sign- or zero-extension on the way out. It enforces input vector framing, zero-padding short packets to a full vector. It also regenerates tlast on the result stream, because the HLS ports carry none.

Parameters:
IN_W, 32, sample width from the vector wrapper
NNET_IN_W, 18, HLS input field width (must be <= IN_W)
NNET_OUT_W, 18, HLS result field width
OUT_W, 32, sample width to the vector wrapper (must be >= NNET_OUT_W)
CNT_W, 16, width of size registers and counters
SAT_IN, 1, 1 = signed saturate input to NNET_IN_W; 0 = truncate to LSBs

Ports:
ap_clk  in  1  single clock for all logic
ap_rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear of state, counters and skid buffers
cfg_pad_en  in  1  1 = zero-pad short input packets to a full vector
cfg_sign_ext  in  1  1 = sign-extend results; 0 = zero-extend
size_in  in  CNT_W  input vector length from the HLS core
size_in_vld  in  1  strobe; latches size_in
size_out  in  CNT_W  result vector length from the HLS core
size_out_vld  in  1  strobe; latches size_out
s_axis_tdata/tlast/tvalid/tready  in/in/in/out  IN_W/1/1/1  samples from the wrapper
m_nnet_tdata/tlast/tvalid/tready  out/out/out/in  NNET_IN_W/1/1/1  input stream to the HLS core
s_nnet_tdata/tvalid/tready  in/in/out  NNET_OUT_W/1/1  results from the HLS core
m_axis_tdata/tlast/tvalid/tready  out/out/out/in  OUT_W/1/1/1  results to the wrapper
stat_vec_in  out  CNT_W  completed input vectors
stat_vec_out  out  CNT_W  completed result vectors
stat_short  out  CNT_W  short packets detected
busy  out  1  high while in_state != IDLE or any skid buffer is occupied

Behaviour:
- Reset (ap_rst_n=0, async) and clear (sync) produce the same state: all tvalid=0, all tlast=0, s_axis_tready=0, s_nnet_tready=0, size regs=0, all counters and stats=0, in_state=IDLE, busy=0.
- Size regs load on their vld strobe.
- Both directions use a 2-entry skid buffer. Latency is 1 cycle and full throughput is sustained. tdata and tlast are held stable while tvalid=1 and tready=0.
- A size of 0 means unconfigured. The path holds its upstream tready=0.
- Loading a new size mid-vector takes effect after the current vector wraps.
- Input conversion, SAT_IN=1: a signed value above 2^(NNET_IN_W-1)-1 clamps to that value; a value below -2^(NNET_IN_W-1) clamps to it. SAT_IN=0: take the low NNET_IN_W bits.
- Input FSM states: IDLE, RUN, PAD.
  - IDLE -> RUN once size_in != 0.
  - RUN: each accepted sample increments in_cnt. m_nnet_tlast=1 when in_cnt==size_in-1. On that beat in_cnt wraps to 0 and stat_vec_in increments.
  - RUN, s_axis_tlast on a beat with in_cnt!=size_in-1: stat_short increments. If cfg_pad_en=1, go to PAD; otherwise the partial vector continues into the next packet.
  - A tlast on the final vector beat is normal and is not counted as short.
  - PAD: s_axis_tready=0. Emit zero samples until the vector completes, with tlast on the final zero, then return to RUN.
  - A long packet (no tlast at the vector boundary) simply wraps and is not an error.
- Output path: extend each result to OUT_W per cfg_sign_ext. out_cnt counts accepted results. m_axis_tlast=1 when out_cnt==size_out-1; on that beat out_cnt wraps and stat_vec_out increments.
- All counters and stats wrap modulo 2^CNT_W, except that stats saturate at all-ones.
- A result handshake and an input handshake in the same cycle are independent and both complete.

Test Plan:
- size_in=4, size_out=2, SAT_IN=1. Send 8 samples, one packet, tlast on beat 8 -> m_nnet_tlast on beats 4 and 8; stat_vec_in=2; stat_short=0.
- Input 0x0002_0000 and 0xFFFD_0000 with NNET_IN_W=18 -> m_nnet_tdata 0x1FFFF and 0x20000.
- pad_en=1, size_in=4, 3-sample packet with tlast -> 3 data beats then 1 zero beat with tlast; s_axis_tready=0 during PAD; stat_short=1.
- Results 0x3FFFF and 0x00001, size_out=2: sign_ext=1 -> 0xFFFFFFFF and 0x00000001, tlast on the second. sign_ext=0 -> first is 0x0003FFFF.
- Random tvalid/tready backpressure, 1000 vectors -> no loss or duplication; output matches the scoreboard; stat_vec_out=1000.
- Assert ap_rst_n=0 asynchronously mid-PAD, then reassert with size_in=0 -> all outputs at reset values; s_axis_tready stays 0 until size_in_vld.

Source files
------------

// File: rtl/nnet_frame_adapter_if.sv
// Stream bundle between the vector wrapper, the frame adapter and the HLS core.
// Handshake: a beat moves on a rising ap_clk edge where tvalid && tready are both 1; the source holds
// tvalid high and tdata/tlast unchanged until that edge, and tready may rise or fall at any time.
interface nnet_frame_adapter_if #(
  parameter int IN_W       = 32,
  parameter int NNET_IN_W  = 18,
  parameter int NNET_OUT_W = 18,
  parameter int OUT_W      = 32
);
  logic [IN_W-1:0]       s_axis_tdata;
  logic                  s_axis_tlast;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;

  logic [NNET_IN_W-1:0]  m_nnet_tdata;
  logic                  m_nnet_tlast;
  logic                  m_nnet_tvalid;
  logic                  m_nnet_tready;

  logic [NNET_OUT_W-1:0] s_nnet_tdata;
  logic                  s_nnet_tvalid;
  logic                  s_nnet_tready;

  logic [OUT_W-1:0]      m_axis_tdata;
  logic                  m_axis_tlast;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  // Environment side: wrapper and HLS core driving the adapter.
  modport master (
    output s_axis_tdata, s_axis_tlast, s_axis_tvalid,
    input  s_axis_tready,
    input  m_nnet_tdata, m_nnet_tlast, m_nnet_tvalid,
    output m_nnet_tready,
    output s_nnet_tdata, s_nnet_tvalid,
    input  s_nnet_tready,
    input  m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );

  // Adapter side.
  modport slave (
    input  s_axis_tdata, s_axis_tlast, s_axis_tvalid,
    output s_axis_tready,
    output m_nnet_tdata, m_nnet_tlast, m_nnet_tvalid,
    input  m_nnet_tready,
    input  s_nnet_tdata, s_nnet_tvalid,
    output s_nnet_tready,
    output m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );
endinterface

// File: rtl/nnet_frame_adapter.sv
// Width/framing adapter between the RFNoC vector wrapper streams and an HLS neural-net core:
// saturating input conversion with vector framing and zero padding, result extension with tlast regeneration.

module nnet_frame_adapter_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_full,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign o_valid = (r_cnt != 2'd0);
  assign o_full  = (r_cnt == 2'd2);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = o_valid && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_clr) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      // The head entry is never overwritten while occupied, so output data stays stable under backpressure.
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end
endmodule

module nnet_frame_adapter #(
  parameter int IN_W       = 32,
  parameter int NNET_IN_W  = 18,
  parameter int NNET_OUT_W = 18,
  parameter int OUT_W      = 32,
  parameter int CNT_W      = 16,
  parameter bit SAT_IN     = 1'b1
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clear,
  input  logic             cfg_pad_en,
  input  logic             cfg_sign_ext,
  input  logic [CNT_W-1:0] size_in,
  input  logic             size_in_vld,
  input  logic [CNT_W-1:0] size_out,
  input  logic             size_out_vld,
  nnet_frame_adapter_if.slave bus,
  output logic [CNT_W-1:0] stat_vec_in,
  output logic [CNT_W-1:0] stat_vec_out,
  output logic [CNT_W-1:0] stat_short,
  output logic             busy,
  output logic [1:0]       dbg_in_state
);
  typedef enum logic [1:0] {IN_IDLE = 2'd0, IN_RUN = 2'd1, IN_PAD = 2'd2} in_state_t;

  localparam logic [NNET_IN_W-1:0] SAT_MAX = {1'b0, {(NNET_IN_W-1){1'b1}}};
  localparam logic [NNET_IN_W-1:0] SAT_MIN = {1'b1, {(NNET_IN_W-1){1'b0}}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  in_state_t          r_in_state;
  in_state_t          w_in_state_nxt;
  logic [CNT_W-1:0]   r_size_in;
  logic [CNT_W-1:0]   r_size_in_act;
  logic [CNT_W-1:0]   r_in_cnt;
  logic [CNT_W-1:0]   r_size_out;
  logic [CNT_W-1:0]   r_size_out_act;
  logic [CNT_W-1:0]   r_out_cnt;
  logic [CNT_W-1:0]   r_stat_vec_in;
  logic [CNT_W-1:0]   r_stat_vec_out;
  logic [CNT_W-1:0]   r_stat_short;

  logic [IN_W-NNET_IN_W:0] w_in_top;
  logic                    w_in_fits;
  logic [NNET_IN_W-1:0]    w_in_conv;
  logic [CNT_W-1:0]        w_in_size;
  logic                    w_in_last;
  logic                    w_in_full;
  logic                    w_in_valid;
  logic [NNET_IN_W:0]      w_in_head;
  logic                    w_s_ready;
  logic                    w_in_push;
  logic [NNET_IN_W-1:0]    w_in_data;
  logic                    w_short;

  logic [OUT_W-1:0]        w_res_sext;
  logic [OUT_W-1:0]        w_res_zext;
  logic [OUT_W-1:0]        w_res_ext;
  logic [CNT_W-1:0]        w_out_size;
  logic                    w_out_last;
  logic                    w_out_full;
  logic                    w_out_ready;
  logic                    w_out_push;
  logic                    w_out_valid;
  logic [OUT_W:0]          w_out_head;

  // Input conversion: the sample fits when every bit from the field sign bit upward agrees.
  assign w_in_top  = bus.s_axis_tdata[IN_W-1:NNET_IN_W-1];
  assign w_in_fits = (&w_in_top) || !(|w_in_top);

  always_comb begin
    w_in_conv = bus.s_axis_tdata[NNET_IN_W-1:0];
    if (SAT_IN && !w_in_fits) w_in_conv = bus.s_axis_tdata[IN_W-1] ? SAT_MIN : SAT_MAX;
  end

  // A newly loaded size is only picked up at a vector boundary.
  assign w_in_size = (r_in_cnt == '0) ? r_size_in : r_size_in_act;
  assign w_in_last = (r_in_cnt == w_in_size - CNT_W'(1));

  always_comb begin
    w_in_state_nxt = r_in_state;
    w_s_ready      = 1'b0;
    w_in_push      = 1'b0;
    w_in_data      = w_in_conv;
    w_short        = 1'b0;
    case (r_in_state)
      IN_IDLE: begin
        if (r_size_in != '0) w_in_state_nxt = IN_RUN;
      end
      IN_RUN: begin
        if (w_in_size == '0) begin
          w_in_state_nxt = IN_IDLE;
        end else begin
          w_s_ready = !w_in_full;
          if (bus.s_axis_tvalid && w_s_ready) begin
            w_in_push = 1'b1;
            if (bus.s_axis_tlast && !w_in_last) begin
              w_short = 1'b1;
              if (cfg_pad_en) w_in_state_nxt = IN_PAD;
            end
          end
        end
      end
      IN_PAD: begin
        w_in_data = '0;
        w_in_push = !w_in_full;
        if (w_in_push && w_in_last) w_in_state_nxt = IN_RUN;
      end
      default: w_in_state_nxt = IN_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)  r_in_state <= IN_IDLE;
    else if (clear) r_in_state <= IN_IDLE;
    else            r_in_state <= w_in_state_nxt;
  end

  nnet_frame_adapter_skid #(.W(NNET_IN_W + 1)) u_in_skid (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .i_clr   (clear),
    .i_push  (w_in_push),
    .i_data  ({w_in_last, w_in_data}),
    .i_ready (bus.m_nnet_tready),
    .o_full  (w_in_full),
    .o_valid (w_in_valid),
    .o_data  (w_in_head)
  );

  assign bus.s_axis_tready = w_s_ready;
  assign bus.m_nnet_tvalid = w_in_valid;
  assign bus.m_nnet_tdata  = w_in_head[NNET_IN_W-1:0];
  assign bus.m_nnet_tlast  = w_in_valid && w_in_head[NNET_IN_W];

  // Result extension and framing.
  assign w_res_sext  = OUT_W'($signed(bus.s_nnet_tdata));
  assign w_res_zext  = OUT_W'(bus.s_nnet_tdata);
  assign w_res_ext   = cfg_sign_ext ? w_res_sext : w_res_zext;
  assign w_out_size  = (r_out_cnt == '0) ? r_size_out : r_size_out_act;
  assign w_out_last  = (r_out_cnt == w_out_size - CNT_W'(1));
  assign w_out_ready = (w_out_size != '0) && !w_out_full;
  assign w_out_push  = bus.s_nnet_tvalid && w_out_ready;

  nnet_frame_adapter_skid #(.W(OUT_W + 1)) u_out_skid (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .i_clr   (clear),
    .i_push  (w_out_push),
    .i_data  ({w_out_last, w_res_ext}),
    .i_ready (bus.m_axis_tready),
    .o_full  (w_out_full),
    .o_valid (w_out_valid),
    .o_data  (w_out_head)
  );

  assign bus.s_nnet_tready = w_out_ready;
  assign bus.m_axis_tvalid = w_out_valid;
  assign bus.m_axis_tdata  = w_out_head[OUT_W-1:0];
  assign bus.m_axis_tlast  = w_out_valid && w_out_head[OUT_W];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_size_in      <= '0;
      r_size_in_act  <= '0;
      r_in_cnt       <= '0;
      r_size_out     <= '0;
      r_size_out_act <= '0;
      r_out_cnt      <= '0;
      r_stat_vec_in  <= '0;
      r_stat_vec_out <= '0;
      r_stat_short   <= '0;
    end else if (clear) begin
      r_size_in      <= '0;
      r_size_in_act  <= '0;
      r_in_cnt       <= '0;
      r_size_out     <= '0;
      r_size_out_act <= '0;
      r_out_cnt      <= '0;
      r_stat_vec_in  <= '0;
      r_stat_vec_out <= '0;
      r_stat_short   <= '0;
    end else begin
      if (size_in_vld)  r_size_in  <= size_in;
      if (size_out_vld) r_size_out <= size_out;
      if (w_in_push) begin
        if (r_in_cnt == '0) r_size_in_act <= r_size_in;
        if (w_in_last) begin
          r_in_cnt      <= '0;
          r_stat_vec_in <= sat_inc(r_stat_vec_in);
        end else begin
          r_in_cnt <= r_in_cnt + CNT_W'(1);
        end
      end
      if (w_short) r_stat_short <= sat_inc(r_stat_short);
      if (w_out_push) begin
        if (r_out_cnt == '0) r_size_out_act <= r_size_out;
        if (w_out_last) begin
          r_out_cnt      <= '0;
          r_stat_vec_out <= sat_inc(r_stat_vec_out);
        end else begin
          r_out_cnt <= r_out_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign stat_vec_in  = r_stat_vec_in;
  assign stat_vec_out = r_stat_vec_out;
  assign stat_short   = r_stat_short;
  assign busy         = (r_in_state != IN_IDLE) || w_in_valid || w_out_valid;
  assign dbg_in_state = r_in_state;
endmodule

// File: tb/tb_nnet_frame_adapter.sv
// Self-checking bench for nnet_frame_adapter: directed framing/conversion cases plus randomized
// traffic with backpressure, checked against a queue-based reference model.
module tb_nnet_frame_adapter;
  localparam int IN_W       = 32;
  localparam int NNET_IN_W  = 18;
  localparam int NNET_OUT_W = 18;
  localparam int OUT_W      = 32;
  localparam int CNT_W      = 16;
  localparam bit SAT_IN     = 1'b1;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             cfg_pad_en = 1'b0;
  logic             cfg_sign_ext = 1'b0;
  logic [CNT_W-1:0] size_in = '0;
  logic             size_in_vld = 1'b0;
  logic [CNT_W-1:0] size_out = '0;
  logic             size_out_vld = 1'b0;
  logic [CNT_W-1:0] stat_vec_in;
  logic [CNT_W-1:0] stat_vec_out;
  logic [CNT_W-1:0] stat_short;
  logic             busy;
  logic [1:0]       dbg_in_state;

  nnet_frame_adapter_if #(
    .IN_W(IN_W), .NNET_IN_W(NNET_IN_W), .NNET_OUT_W(NNET_OUT_W), .OUT_W(OUT_W)
  ) bus ();

  nnet_frame_adapter #(
    .IN_W(IN_W), .NNET_IN_W(NNET_IN_W), .NNET_OUT_W(NNET_OUT_W),
    .OUT_W(OUT_W), .CNT_W(CNT_W), .SAT_IN(SAT_IN)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .clear        (clear),
    .cfg_pad_en   (cfg_pad_en),
    .cfg_sign_ext (cfg_sign_ext),
    .size_in      (size_in),
    .size_in_vld  (size_in_vld),
    .size_out     (size_out),
    .size_out_vld (size_out_vld),
    .bus          (bus),
    .stat_vec_in  (stat_vec_in),
    .stat_vec_out (stat_vec_out),
    .stat_short   (stat_short),
    .busy         (busy),
    .dbg_in_state (dbg_in_state)
  );

  // ---------------- clock / reset ----------------
  always #5 ap_clk = ~ap_clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NNET_IN_W:0] exp_in_q[$];
  logic [OUT_W:0]     exp_out_q[$];
  int sz_in = 0, sz_out = 0;
  int m_pos = 0, m_vec_in = 0, m_short = 0;
  int o_pos = 0, m_vec_out = 0;

  function automatic logic [NNET_IN_W-1:0] ref_conv(input logic [IN_W-1:0] d);
    longint v, hi, lo;
    v  = longint'($signed(d));
    hi = (longint'(1) << (NNET_IN_W-1)) - 1;
    lo = -(longint'(1) << (NNET_IN_W-1));
    if (SAT_IN) begin
      if (v > hi) v = hi;
      else if (v < lo) v = lo;
    end
    return v[NNET_IN_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] ref_ext(input logic [NNET_OUT_W-1:0] d, input logic sx);
    longint v;
    v = longint'(d);
    if (sx && v >= (longint'(1) << (NNET_OUT_W-1))) v = v - (longint'(1) << NNET_OUT_W);
    return v[OUT_W-1:0];
  endfunction

  // One wrapper sample; a short packet end optionally appends the zeros that complete the vector.
  task automatic model_in_beat(input logic [IN_W-1:0] d, input bit pkt_last);
    bit vlast;
    vlast = (m_pos == sz_in - 1);
    exp_in_q.push_back({vlast, ref_conv(d)});
    m_pos = vlast ? 0 : m_pos + 1;
    if (vlast) m_vec_in++;
    if (pkt_last && !vlast) begin
      m_short++;
      if (cfg_pad_en) begin
        int remain;
        remain = sz_in - m_pos;
        for (int k = 0; k < remain; k++)
          exp_in_q.push_back({(k == remain - 1), {NNET_IN_W{1'b0}}});
        m_pos = 0;
        m_vec_in++;
      end
    end
  endtask

  task automatic model_out_beat(input logic [NNET_OUT_W-1:0] d);
    bit vlast;
    vlast = (o_pos == sz_out - 1);
    exp_out_q.push_back({vlast, ref_ext(d, cfg_sign_ext)});
    o_pos = vlast ? 0 : o_pos + 1;
    if (vlast) m_vec_out++;
  endtask

  // ---------------- sinks / monitors ----------------
  int nn_mode = 0;  // 0 random ready, 1 always ready, 2 never ready

  initial begin : nnet_sink
    bus.m_nnet_tready = 1'b0;
    forever begin
      @(negedge ap_clk);
      bus.m_nnet_tready = (nn_mode == 1) || (nn_mode == 0 && $urandom_range(0, 3) != 0);
      #1;
      if (ap_rst_n && bus.m_nnet_tvalid && bus.m_nnet_tready) begin
        check_eq("m_nnet_expected", 64'(exp_in_q.size() != 0), 64'd1);
        if (exp_in_q.size() != 0)
          check_eq("m_nnet_beat", 64'({bus.m_nnet_tlast, bus.m_nnet_tdata}), 64'(exp_in_q.pop_front()));
      end
    end
  end

  initial begin : axis_sink
    bus.m_axis_tready = 1'b0;
    forever begin
      @(negedge ap_clk);
      bus.m_axis_tready = ($urandom_range(0, 3) != 0);
      #1;
      if (ap_rst_n && bus.m_axis_tvalid && bus.m_axis_tready) begin
        check_eq("m_axis_expected", 64'(exp_out_q.size() != 0), 64'd1);
        if (exp_out_q.size() != 0)
          check_eq("m_axis_beat", 64'({bus.m_axis_tlast, bus.m_axis_tdata}), 64'(exp_out_q.pop_front()));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic axis_send(input logic [IN_W-1:0] d, input logic l, input int max_gap);
    bit done;
    int waited;
    done = 1'b0;
    waited = 0;
    repeat ($urandom_range(0, max_gap)) @(negedge ap_clk);
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    bus.s_axis_tvalid = 1'b1;
    while (!done && waited < 1000) begin
      #1;
      if (bus.s_axis_tready) done = 1'b1;
      @(negedge ap_clk);
      waited++;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    check_eq("s_axis_accept", 64'(done), 64'd1);
  endtask

  task automatic nnet_send(input logic [NNET_OUT_W-1:0] d, input int max_gap);
    bit done;
    int waited;
    done = 1'b0;
    waited = 0;
    repeat ($urandom_range(0, max_gap)) @(negedge ap_clk);
    bus.s_nnet_tdata  = d;
    bus.s_nnet_tvalid = 1'b1;
    while (!done && waited < 1000) begin
      #1;
      if (bus.s_nnet_tready) done = 1'b1;
      @(negedge ap_clk);
      waited++;
    end
    bus.s_nnet_tvalid = 1'b0;
    check_eq("s_nnet_accept", 64'(done), 64'd1);
  endtask

  function automatic logic [IN_W-1:0] rand_sample();
    logic [IN_W-1:0] v;
    logic [17:0]     s;
    case ($urandom_range(0, 2))
      0: v = $urandom();
      1: begin
        s = 18'($urandom_range(0, 262143));
        v = {{(IN_W-18){s[17]}}, s};
      end
      default: begin
        case ($urandom_range(0, 3))
          0: v = 32'h0001_FFFF;
          1: v = 32'hFFFE_0000;
          2: v = 32'h0002_0000;
          default: v = 32'hFFFD_FFFF;
        endcase
      end
    endcase
    return v;
  endfunction

  task automatic send_in_packet(input int len, input int max_gap);
    logic [IN_W-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = rand_sample();
      model_in_beat(d, i == len - 1);
      axis_send(d, i == len - 1, max_gap);
    end
  endtask

  task automatic set_size_in(input int v);
    @(negedge ap_clk);
    size_in = CNT_W'(v);
    size_in_vld = 1'b1;
    sz_in = v;
    @(negedge ap_clk);
    size_in_vld = 1'b0;
  endtask

  task automatic set_size_out(input int v);
    @(negedge ap_clk);
    size_out = CNT_W'(v);
    size_out_vld = 1'b1;
    sz_out = v;
    @(negedge ap_clk);
    size_out_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_in_q.size() != 0 || exp_out_q.size() != 0) && n < 6000) begin
      @(negedge ap_clk);
      n++;
    end
    repeat (3) @(negedge ap_clk);
    check_eq("drain_in", 64'(exp_in_q.size()), 64'd0);
    check_eq("drain_out", 64'(exp_out_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_m_nnet_tvalid"}, 64'(bus.m_nnet_tvalid), 64'd0);
    check_eq({tag, "_m_nnet_tlast"},  64'(bus.m_nnet_tlast),  64'd0);
    check_eq({tag, "_m_axis_tvalid"}, 64'(bus.m_axis_tvalid), 64'd0);
    check_eq({tag, "_m_axis_tlast"},  64'(bus.m_axis_tlast),  64'd0);
    check_eq({tag, "_s_axis_tready"}, 64'(bus.s_axis_tready), 64'd0);
    check_eq({tag, "_s_nnet_tready"}, 64'(bus.s_nnet_tready), 64'd0);
    check_eq({tag, "_stat_vec_in"},   64'(stat_vec_in),       64'd0);
    check_eq({tag, "_stat_vec_out"},  64'(stat_vec_out),      64'd0);
    check_eq({tag, "_stat_short"},    64'(stat_short),        64'd0);
    check_eq({tag, "_busy"},          64'(busy),              64'd0);
    check_eq({tag, "_state"},         64'(dbg_in_state),      64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_nnet_tdata  = '0;
    bus.s_nnet_tvalid = 1'b0;

    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    #1;
    check_idle_outputs("reset");

    // Two full vectors in one packet, no short count.
    set_size_in(4);
    set_size_out(2);
    send_in_packet(8, 1);
    wait_drain();
    check_eq("t1_stat_vec_in", 64'(stat_vec_in), 64'd2);
    check_eq("t1_stat_short",  64'(stat_short),  64'd0);

    // Saturation corners, one vector of four.
    exp_in_q.push_back({1'b0, 18'h1FFFF});
    exp_in_q.push_back({1'b0, 18'h20000});
    exp_in_q.push_back({1'b0, 18'h1FFFF});
    exp_in_q.push_back({1'b1, 18'h20000});
    m_vec_in++;
    axis_send(32'h0002_0000, 1'b0, 0);
    axis_send(32'hFFFD_0000, 1'b0, 0);
    axis_send(32'h0001_FFFF, 1'b0, 0);
    axis_send(32'hFFFE_0000, 1'b1, 0);
    wait_drain();
    check_eq("t2_stat_vec_in", 64'(stat_vec_in), 64'd3);

    // Short packet padded with one zero beat.
    cfg_pad_en = 1'b1;
    send_in_packet(3, 0);
    #1;
    check_eq("t3_pad_state", 64'(dbg_in_state), 64'd2);
    check_eq("t3_pad_ready", 64'(bus.s_axis_tready), 64'd0);
    wait_drain();
    check_eq("t3_stat_short",  64'(stat_short),  64'd1);
    check_eq("t3_stat_vec_in", 64'(stat_vec_in), 64'd4);

    // Result extension, both modes.
    cfg_sign_ext = 1'b1;
    exp_out_q.push_back({1'b0, 32'hFFFF_FFFF});
    exp_out_q.push_back({1'b1, 32'h0000_0001});
    nnet_send(18'h3FFFF, 0);
    nnet_send(18'h00001, 0);
    wait_drain();
    cfg_sign_ext = 1'b0;
    exp_out_q.push_back({1'b0, 32'h0003_FFFF});
    exp_out_q.push_back({1'b1, 32'h0000_0001});
    nnet_send(18'h3FFFF, 0);
    nnet_send(18'h00001, 0);
    wait_drain();
    check_eq("t4_stat_vec_out", 64'(stat_vec_out), 64'd2);

    // Synchronous clear returns to the reset state.
    @(negedge ap_clk);
    clear = 1'b1;
    @(negedge ap_clk);
    clear = 1'b0;
    #1;
    check_idle_outputs("clear");
    m_pos = 0; m_vec_in = 0; m_short = 0; o_pos = 0; m_vec_out = 0;

    // Randomized traffic on both paths concurrently.
    cfg_sign_ext = 1'($urandom_range(0, 1));
    set_size_in($urandom_range(1, 6));
    set_size_out($urandom_range(1, 4));
    fork
      begin
        for (int p = 0; p < 80; p++) begin
          if (p % 20 == 0) cfg_pad_en = 1'((p / 20) % 2);
          send_in_packet($urandom_range(1, 10), 2);
        end
      end
      begin
        logic [NNET_OUT_W-1:0] r;
        for (int v = 0; v < 1000; v++) begin
          for (int b = 0; b < sz_out; b++) begin
            r = NNET_OUT_W'($urandom());
            model_out_beat(r);
            nnet_send(r, 2);
          end
        end
      end
    join
    wait_drain();
    check_eq("rand_stat_vec_in",  64'(stat_vec_in),  64'(m_vec_in));
    check_eq("rand_stat_short",   64'(stat_short),   64'(m_short));
    check_eq("rand_stat_vec_out", 64'(stat_vec_out), 64'd1000);
    check_eq("rand_model_vec_out", 64'(m_vec_out),   64'd1000);

    // Asynchronous reset in the middle of padding.
    @(negedge ap_clk);
    clear = 1'b1;
    @(negedge ap_clk);
    clear = 1'b0;
    nn_mode = 2;
    cfg_pad_en = 1'b1;
    set_size_in(4);
    axis_send(32'h0000_1234, 1'b1, 0);
    #1;
    check_eq("t6_pad_state", 64'(dbg_in_state), 64'd2);
    repeat (3) @(negedge ap_clk);
    #1;
    check_eq("t6_pad_held",  64'(dbg_in_state),      64'd2);
    check_eq("t6_busy",      64'(busy),              64'd1);
    check_eq("t6_nn_valid",  64'(bus.m_nnet_tvalid), 64'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    nn_mode = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge ap_clk);
      #1;
      check_eq("t6_ready_unconfigured", 64'(bus.s_axis_tready), 64'd0);
    end
    set_size_in(4);
    @(negedge ap_clk);
    #1;
    check_eq("t6_ready_configured", 64'(bus.s_axis_tready), 64'd1);

    repeat (2) @(negedge ap_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
